// File: rtl/bin2led_pkg.sv
// bin2led_pkg -- shared types and constants for the stopwatch LED indicator.
//   mode_e  : LED encoding (binary quotient or thermometer bar)
//   state_e : divider control FSM states
//   DEFAULT_DIVISOR : one minute expressed in centiseconds
// Optional feature macro used by this block: BIN2LED_BLINK_EN.
package bin2led_pkg;

  typedef enum logic {
    MODE_BIN   = 1'b0,
    MODE_THERM = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_LOAD = 2'd2
  } state_e;

  localparam int DEFAULT_DIVISOR = 6000;

endpackage

// File: rtl/bin2led_div_blinker.sv
// led_blinker -- phase generator for blinking the LEDs on overflow.
// Built only when BIN2LED_BLINK_EN is defined.
//   clk, rst  : clock, asynchronous active-high reset
//   clr       : restart the blink period with the phase "on"
//   en        : advance the blink counter
//   phase_on  : 1 while the LEDs should be lit
`ifdef BIN2LED_BLINK_EN
module led_blinker #(
  parameter int BLINK_CYCLES = 25_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic phase_on
);

  localparam int CW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      phase_on <= 1'b1;
    end else if (clr) begin
      cnt      <= '0;
      phase_on <= 1'b1;
    end else if (en) begin
      if (cnt == CW'(BLINK_CYCLES - 1)) begin
        cnt      <= '0;
        phase_on <= ~phase_on;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule
`endif

// File: rtl/bin2led_div.sv
// bin2led_div -- divides an elapsed-time count by a fixed unit with a
// restoring shift-subtract divider (one quotient bit per cycle) and drives
// a bank of LEDs with the quotient in binary or thermometer form.
//   clk, rst   : clock, asynchronous active-high reset
//   in_valid   : in_bin holds a count to convert
//   in_bin     : binary count (WIDTH bits)
//   in_ready   : block is idle and accepts a count this cycle
//   led        : LED drive, held between results
//   out_valid  : one-cycle pulse when led/overflow were just updated
//   overflow   : quotient did not fit the LED range
// Latency from accept to out_valid is WIDTH+1 cycles.
// Optional macro BIN2LED_BLINK_EN: blink the LEDs while overflow is set.
module bin2led_div
  import bin2led_pkg::*;
#(
  parameter int    WIDTH        = 16,
  parameter int    DIVISOR      = DEFAULT_DIVISOR,
  parameter int    LEDS         = 4,
  parameter mode_e MODE         = MODE_BIN,
  parameter int    BLINK_CYCLES = 25_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_bin,
  output logic             in_ready,
  output logic [LEDS-1:0]  led,
  output logic             out_valid,
  output logic             overflow
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  // Divisor widened to the trial-remainder width.
  localparam logic [WIDTH+1:0] DIV_T   = (WIDTH + 2)'(DIVISOR);
  // Largest quotient representable on the LEDs in binary form.
  localparam logic [WIDTH:0]   BIN_MAX = (WIDTH + 1)'((64'(1) << LEDS) - 64'(1));

  generate
    if (DIVISOR < 1 || 64'(DIVISOR) > ((64'(1) << WIDTH) - 64'(1))) begin : g_bad_divisor
      $error("bin2led_div: DIVISOR must be in 1..2^WIDTH-1");
    end
    if (LEDS < 1 || LEDS > WIDTH) begin : g_bad_leds
      $error("bin2led_div: LEDS must be in 1..WIDTH");
    end
    if (BLINK_CYCLES < 1) begin : g_bad_blink
      $error("bin2led_div: BLINK_CYCLES must be positive");
    end
  endgenerate

  state_e           state;
  logic [CNT_W-1:0] step_cnt;
  logic [WIDTH-1:0] dvd_q;     // dividend in, quotient out (shifted in from LSB)
  logic [WIDTH:0]   rem_q;
  logic [LEDS-1:0]  led_q;
  logic             overflow_q;
  logic             out_valid_q;

  logic [WIDTH+1:0] trial;
  logic             trial_ge;

  // Map a quotient to {overflow, led} for the configured encoding.
  function automatic logic [LEDS:0] led_map(input logic [WIDTH-1:0] q);
    logic [LEDS-1:0] l;
    logic            o;
    l = '0;
    o = 1'b0;
    if (MODE == MODE_THERM) begin
      for (int i = 0; i < LEDS; i++) begin
        l[i] = ({1'b0, q} > (WIDTH + 1)'(i));
      end
      o = ({1'b0, q} > (WIDTH + 1)'(LEDS));
    end else begin
      if ({1'b0, q} > BIN_MAX) begin
        l = '1;
        o = 1'b1;
      end else begin
        l = q[LEDS-1:0];
      end
    end
    return {o, l};
  endfunction

  assign trial    = {rem_q, dvd_q[WIDTH-1]};
  assign trial_ge = (trial >= DIV_T);
  assign in_ready = (state == ST_IDLE);

  // Control: FSM, step counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      step_cnt    <= '0;
      led_q       <= '0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (in_valid) begin
            step_cnt <= CNT_W'(WIDTH);
            state    <= ST_DIV;
          end
        end
        ST_DIV: begin
          step_cnt <= step_cnt - 1'b1;
          if (step_cnt == CNT_W'(1)) begin
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          {overflow_q, led_q} <= led_map(dvd_q);
          out_valid_q         <= 1'b1;
          state               <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Datapath: one restoring shift-subtract step per DIV cycle.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && in_valid) begin
      dvd_q <= in_bin;
      rem_q <= '0;
    end else if (state == ST_DIV) begin
      rem_q <= (WIDTH + 1)'(trial_ge ? (trial - DIV_T) : trial);
      dvd_q <= {dvd_q[WIDTH-2:0], trial_ge};
    end
  end

  assign out_valid = out_valid_q;
  assign overflow  = overflow_q;

`ifdef BIN2LED_BLINK_EN
  logic phase_on;

  // Blink period restarts with every new result.
  led_blinker #(
    .BLINK_CYCLES(BLINK_CYCLES)
  ) u_blinker (
    .clk     (clk),
    .rst     (rst),
    .clr     (state == ST_LOAD),
    .en      (overflow_q),
    .phase_on(phase_on)
  );

  assign led = (overflow_q && !phase_on) ? '0 : led_q;
`else
  assign led = led_q;
`endif

endmodule

// File: tb/tb_bin2led_div.sv
// tb_bin2led_div -- directed bench for bin2led_div with three instances
// sharing one input stream: binary/4 LEDs, binary/3 LEDs, thermometer/4 LEDs.
module tb_bin2led_div;
  import bin2led_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_bin = '0;

  logic       rdy4, rdy3, rdyt;
  logic       ov4, ov3, ovt;
  logic       ovf4, ovf3, ovft;
  logic [3:0] led4, ledt;
  logic [2:0] led3;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bin2led_div #(.LEDS(4), .MODE(MODE_BIN), .BLINK_CYCLES(4)) u_bin4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bin(in_bin),
    .in_ready(rdy4), .led(led4), .out_valid(ov4), .overflow(ovf4));

  bin2led_div #(.LEDS(3), .MODE(MODE_BIN), .BLINK_CYCLES(4)) u_bin3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bin(in_bin),
    .in_ready(rdy3), .led(led3), .out_valid(ov3), .overflow(ovf3));

  bin2led_div #(.LEDS(4), .MODE(MODE_THERM), .BLINK_CYCLES(4)) u_therm (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bin(in_bin),
    .in_ready(rdyt), .led(ledt), .out_valid(ovt), .overflow(ovft));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Present v for one accept edge, then wait (bounded) for out_valid.
  // Returns at the negedge where out_valid is seen; lat counts cycles after accept.
  task automatic convert(input logic [15:0] v, output int lat);
    @(negedge clk);
    in_valid = 1'b1;
    in_bin   = v;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!ov4 && lat < 40);
  endtask

  typedef struct {
    logic [15:0] bin;
    logic [3:0]  l4;
    logic        o4;
    logic [2:0]  l3;
    logic        o3;
    logic [3:0]  lt;
    logic        ot;
  } vec_t;

  vec_t vecs[12];

  int          lat;
  int          ev_edge[$];
  logic [3:0]  ev_led[$];
  int          exp_edge[4] = '{17, 35, 53, 71};
  logic [3:0]  exp_led[4]  = '{4'd0, 4'd3, 4'd6, 4'd9};
  int          spurious;
  logic [2:0]  blink_exp;

  initial begin
    //            bin     l4     o4    l3     o3    lt     ot
    vecs[0]  = '{16'd12345, 4'b0010, 1'b0, 3'b010, 1'b0, 4'b0011, 1'b0};
    vecs[1]  = '{16'd65535, 4'b1010, 1'b0, 3'b111, 1'b1, 4'b1111, 1'b1};
    vecs[2]  = '{16'd18000, 4'b0011, 1'b0, 3'b011, 1'b0, 4'b0111, 1'b0};
    vecs[3]  = '{16'd30000, 4'b0101, 1'b0, 3'b101, 1'b0, 4'b1111, 1'b1};
    vecs[4]  = '{16'd0,     4'b0000, 1'b0, 3'b000, 1'b0, 4'b0000, 1'b0};
    vecs[5]  = '{16'd5999,  4'b0000, 1'b0, 3'b000, 1'b0, 4'b0000, 1'b0};
    vecs[6]  = '{16'd6000,  4'b0001, 1'b0, 3'b001, 1'b0, 4'b0001, 1'b0};
    vecs[7]  = '{16'd47999, 4'b0111, 1'b0, 3'b111, 1'b0, 4'b1111, 1'b1};
    vecs[8]  = '{16'd48000, 4'b1000, 1'b0, 3'b111, 1'b1, 4'b1111, 1'b1};
    vecs[9]  = '{16'd24000, 4'b0100, 1'b0, 3'b100, 1'b0, 4'b1111, 1'b0};
    vecs[10] = '{16'd59999, 4'b1001, 1'b0, 3'b111, 1'b1, 4'b1111, 1'b1};
    vecs[11] = '{16'd12000, 4'b0010, 1'b0, 3'b010, 1'b0, 4'b0011, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_led4", 32'(led4), 32'h0);
    check("reset_ovf3", 32'(ovf3), 32'h0);
    check("reset_out_valid", 32'(ov4), 32'h0);
    check("reset_in_ready", 32'(rdy4), 32'h1);
    rst = 1'b0;
    @(negedge clk);

    // Vector table
    for (int i = 0; i < 12; i++) begin
      convert(vecs[i].bin, lat);
      check($sformatf("latency[%0d]", i), 32'(lat), 32'd17);
      check($sformatf("ov3[%0d]", i), 32'(ov3), 32'h1);
      check($sformatf("ovt[%0d]", i), 32'(ovt), 32'h1);
      check($sformatf("ready_with_valid[%0d]", i), 32'(rdy4), 32'h1);
      check($sformatf("led4[%0d]", i), 32'(led4), 32'(vecs[i].l4));
      check($sformatf("ovf4[%0d]", i), 32'(ovf4), 32'(vecs[i].o4));
      check($sformatf("led3[%0d]", i), 32'(led3), 32'(vecs[i].l3));
      check($sformatf("ovf3[%0d]", i), 32'(ovf3), 32'(vecs[i].o3));
      check($sformatf("ledt[%0d]", i), 32'(ledt), 32'(vecs[i].lt));
      check($sformatf("ovft[%0d]", i), 32'(ovft), 32'(vecs[i].ot));
      @(negedge clk);
      check($sformatf("pulse_end[%0d]", i), 32'(ov4), 32'h0);
      check($sformatf("led4_held[%0d]", i), 32'(led4), 32'(vecs[i].l4));
    end

    // Back-to-back: in_valid held high, in_bin changing every cycle.
    // Accepts expected at edges 0, 18, 36, 54 -> results after 17, 35, 53, 71.
    for (int c = 0; c <= 72; c++) begin
      @(negedge clk);
      if (ov4) begin
        ev_edge.push_back(c - 1);
        ev_led.push_back(led4);
      end
      in_valid = (c < 72);
      in_bin   = 16'(c * 1000 + 500);
    end
    in_valid = 1'b0;
    check("b2b_result_count", 32'(ev_edge.size()), 32'd4);
    for (int i = 0; i < 4 && i < ev_edge.size(); i++) begin
      check($sformatf("b2b_edge[%0d]", i), 32'(ev_edge[i]), 32'(exp_edge[i]));
      check($sformatf("b2b_led[%0d]", i), 32'(ev_led[i]), 32'(exp_led[i]));
    end

    // Reset five cycles into DIV: outputs clear at once, no result follows.
    @(negedge clk);
    in_valid = 1'b1;
    in_bin   = 16'd65535;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_reset_busy", 32'(rdy4), 32'h0);
    rst = 1'b1;
    #1;
    check("midrst_led4", 32'(led4), 32'h0);
    check("midrst_led3", 32'(led3), 32'h0);
    check("midrst_ovf3", 32'(ovf3), 32'h0);
    check("midrst_in_ready", 32'(rdy4), 32'h1);
    check("midrst_out_valid", 32'(ov4), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    spurious = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (ov4 || ov3 || ovt) spurious++;
    end
    check("midrst_no_out_valid", 32'(spurious), 32'd0);
    convert(16'd12345, lat);
    check("post_rst_latency", 32'(lat), 32'd17);
    check("post_rst_led4", 32'(led4), 32'h2);
    check("post_rst_ovf4", 32'(ovf4), 32'h0);

    // Overflow display over time, then a non-overflow result.
    convert(16'd65535, lat);
    check("ovf_latency", 32'(lat), 32'd17);
    check("ovf_flag3", 32'(ovf3), 32'h1);
    for (int j = 0; j < 16; j++) begin
      if (j > 0) @(negedge clk);
`ifdef BIN2LED_BLINK_EN
      blink_exp = (((j / 4) % 2) == 0) ? 3'b111 : 3'b000;
`else
      blink_exp = 3'b111;
`endif
      check($sformatf("ovf_led3[%0d]", j), 32'(led3), 32'(blink_exp));
      check($sformatf("ovf_held3[%0d]", j), 32'(ovf3), 32'h1);
    end
    convert(16'd12345, lat);
    for (int j = 0; j < 10; j++) begin
      if (j > 0) @(negedge clk);
      check($sformatf("steady_led3[%0d]", j), 32'(led3), 32'h2);
      check($sformatf("steady_ovf3[%0d]", j), 32'(ovf3), 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
